// File: rtl/mem_pkg.sv
// Shared types for the memory responder: FSM state encoding and funct3
// access-size codes.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Codes 011, 110 and 111 have no defined access size.
    function automatic logic f3_illegal(input logic [2:0] f3);
        return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between a core (master) and the memory responder
// (slave). Clock and reset are carried as plain module ports.
interface mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_funct3,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_funct3,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );

endinterface

// File: rtl/mem_array.sv
// Single-port synchronous RAM, DEPTH_WORDS x 32 bits, per-byte write
// enables and registered read data (read-before-write on the same word).
module mem_array #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
    input  logic [3:0]                     we_i,
    input  logic [31:0]                    wdata_i,
    output logic [31:0]                    rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Byte-lane writes and registered read of the addressed word.
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (we_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one load/store at a time, waits WAIT_CYCLES,
// then returns a single-cycle response. Byte-lane selection and load
// extension live here; storage is in mem_array.
// Optional feature: define MEM_MISALIGN_TRAP_EN to fault misaligned H/W
// accesses instead of silently aligning them.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        write_q;
    logic [AW+1:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_error_q;

    logic        ready;
    logic        accept;
    logic        enter_rsp;
    logic        cur_write;
    logic [AW+1:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [2:0]  cur_f3;
    logic [1:0]  byte_off;
    logic        fault;
    logic [AW-1:0] word_idx;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] shifted;
    logic [31:0] rsp_rdata_d;
    logic        rsp_error_d;
    logic        unused_addr_hi;

    assign ready  = (state_q == IDLE) && !rst;
    assign accept = bus.req_valid && ready;

    // The store commits on the edge that enters RESPOND; with zero wait
    // that edge is the accepting edge itself.
    assign enter_rsp = ((state_q == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                       ((state_q == WAIT) && (cnt_q == 4'd1));

    assign unused_addr_hi = ^bus.req_addr[31:AW+2];

    // In IDLE the RAM is driven from the live bus so a zero-wait request
    // can read/write on its accepting edge; otherwise from the latched copy.
    always_comb begin
        if (state_q == IDLE) begin
            cur_write = bus.req_write;
            cur_addr  = bus.req_addr[AW+1:0];
            cur_wdata = bus.req_wdata;
            cur_f3    = bus.req_funct3;
        end else begin
            cur_write = write_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_f3    = funct3_q;
        end
    end

    // Fault detection and effective byte offset within the word.
    always_comb begin
        case (cur_f3)
            F3_H, F3_HU: byte_off = {cur_addr[1], 1'b0};
            F3_W:        byte_off = 2'b00;
            default:     byte_off = cur_addr[1:0];
        endcase
`ifdef MEM_MISALIGN_TRAP_EN
        fault = f3_illegal(cur_f3) ||
                (((cur_f3 == F3_H) || (cur_f3 == F3_HU)) && cur_addr[0]) ||
                ((cur_f3 == F3_W) && (cur_addr[1:0] != 2'b00));
`else
        fault = f3_illegal(cur_f3);
`endif
    end

    assign word_idx = cur_addr[AW+1:2];

    // Store lane enables and lane-replicated write data.
    always_comb begin
        ram_we = '0;
        case (cur_f3[1:0])
            2'b00:   ram_wdata = {4{cur_wdata[7:0]}};
            2'b01:   ram_wdata = {2{cur_wdata[15:0]}};
            default: ram_wdata = cur_wdata;
        endcase
        if (enter_rsp && cur_write && !fault) begin
            case (cur_f3[1:0])
                2'b00:   ram_we = 4'b0001 << byte_off;
                2'b01:   ram_we = byte_off[1] ? 4'b1100 : 4'b0011;
                default: ram_we = '1;
            endcase
        end
    end

    // Load data: shift addressed lanes down, then sign/zero extend.
    always_comb begin
        shifted     = ram_rdata >> {byte_off, 3'b000};
        rsp_error_d = fault;
        rsp_rdata_d = '0;
        if (!cur_write && !fault) begin
            case (cur_f3)
                F3_B:    rsp_rdata_d = {{24{shifted[7]}}, shifted[7:0]};
                F3_H:    rsp_rdata_d = {{16{shifted[15]}}, shifted[15:0]};
                F3_W:    rsp_rdata_d = shifted;
                F3_BU:   rsp_rdata_d = {24'h0, shifted[7:0]};
                F3_HU:   rsp_rdata_d = {16'h0, shifted[15:0]};
                default: rsp_rdata_d = '0;
            endcase
        end
    end

    // Request FSM with request latch and registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            funct3_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        write_q  <= bus.req_write;
                        addr_q   <= bus.req_addr[AW+1:0];
                        wdata_q  <= bus.req_wdata;
                        funct3_q <= bus.req_funct3;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= RESPOND;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_q <= RESPOND;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESPOND: begin
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= rsp_rdata_d;
                    rsp_error_q <= rsp_error_d;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;

    mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk_i   (clk),
        .addr_i  (word_idx),
        .we_i    (ram_we),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: requests push expected responses
// into a queue; a negedge monitor pops and compares each response.
module tb_mem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned WAITC = 2;
    localparam int unsigned BYTES = DEPTH * 4;

    typedef struct {
        string       name;
        logic [31:0] d;
        logic        e;
        int unsigned due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int unsigned errors = 0;
    int unsigned checks = 0;
    exp_t        sbq[$];
    exp_t        mon_e;
    logic [7:0]  mem_m [BYTES];

    mem_responder_if bus ();

    mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_CYCLES(WAITC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte-addressed reference memory; returns the response a request earns.
    task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [2:0] f, output logic [31:0] rd, output logic er);
        int unsigned size;
        int unsigned base;
        logic [31:0] v;
        rd = 32'h0;
        er = 1'b0;
        size = 0;
        case (f)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        if (size == 0) begin
            er = 1'b1;
            return;
        end
        base = a % BYTES;
        if (base % size != 0) begin
`ifdef MEM_MISALIGN_TRAP_EN
            er = 1'b1;
            return;
`else
            base = base - (base % size);
`endif
        end
        if (w) begin
            for (int unsigned i = 0; i < size; i++) mem_m[base + i] = d[8*i +: 8];
            return;
        end
        v = 32'h0;
        for (int unsigned i = 0; i < size; i++) v = v | (32'(mem_m[base + i]) << (8 * i));
        if (f < 3'd4 && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (f < 3'd4 && size == 2 && v[15]) v = v | 32'hFFFF_0000;
        rd = v;
    endtask

    // mode 0: untracked, 1: model expectation, 2: explicit expectation xd/xe
    task automatic issue(input string nm, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f, input int mode,
                         input logic [31:0] xd, input logic xe);
        int   n;
        exp_t e;
        logic [31:0] md;
        logic me;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        bus.req_funct3 = f;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.req_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: req_ready=%b after %0d cycles, required 1", nm, bus.req_ready, n);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        if (mode != 0) begin
            model_access(w, a, d, f, md, me);
            if (mode == 2) begin
                md = xd;
                me = xe;
            end
            e.name = nm;
            e.d    = md;
            e.e    = me;
            e.due  = cyc + WAITC + 1;
            sbq.push_back(e);
        end
    endtask

    task automatic check_bit(input string nm, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, required %b", nm, act, req);
        end
    endtask

    // Response monitor: every rsp_valid must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: rsp_valid=1 at cycle %0d, required no response", cyc);
            end else begin
                mon_e = sbq.pop_front();
                checks += 3;
                if (bus.rsp_rdata !== mon_e.d) begin
                    errors++;
                    $display("FAIL %s_rdata: got %08h, required %08h", mon_e.name, bus.rsp_rdata, mon_e.d);
                end
                if (bus.rsp_error !== mon_e.e) begin
                    errors++;
                    $display("FAIL %s_error: got %b, required %b", mon_e.name, bus.rsp_error, mon_e.e);
                end
                if (cyc != mon_e.due) begin
                    errors++;
                    $display("FAIL %s_latency: response at cycle %0d, required %0d", mon_e.name, cyc, mon_e.due);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] ra, rd;
        logic [2:0]  rf;
        logic        rw;

        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.req_funct3 = 3'b000;

        // Reset state
        repeat (2) @(negedge clk);
        check_bit("rst_req_ready", bus.req_ready, 1'b0);
        check_bit("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check_bit("rst_rsp_error", bus.rsp_error, 1'b0);
        checks++;
        if (bus.rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_rsp_rdata: got %08h, required 00000000", bus.rsp_rdata);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_bit("post_rst_ready", bus.req_ready, 1'b1);

        // Fill storage so every later load has a known reference value
        for (int unsigned w = 0; w < DEPTH; w++) begin
            issue("init_sw", 1'b1, w * 4, $urandom, 3'b010, 1, 32'h0, 1'b0);
        end

        // Directed cases
        issue("sw_10",   1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 2, 32'h0, 1'b0);
        issue("lw_10",   1'b0, 32'h10, 32'h0, 3'b010, 2, 32'hDEADBEEF, 1'b0);
        issue("lb_13",   1'b0, 32'h13, 32'h0, 3'b000, 2, 32'hFFFFFFDE, 1'b0);
        issue("lbu_13",  1'b0, 32'h13, 32'h0, 3'b100, 2, 32'h000000DE, 1'b0);
        issue("lh_12",   1'b0, 32'h12, 32'h0, 3'b001, 2, 32'hFFFFDEAD, 1'b0);
        issue("lhu_10",  1'b0, 32'h10, 32'h0, 3'b101, 2, 32'h0000BEEF, 1'b0);
        issue("sb_11",   1'b1, 32'h11, 32'h55, 3'b000, 2, 32'h0, 1'b0);
        issue("lw_10b",  1'b0, 32'h10, 32'h0, 3'b010, 2, 32'hDEAD55EF, 1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
        issue("lw_12",   1'b0, 32'h12, 32'h0, 3'b010, 2, 32'h0, 1'b1);
`else
        issue("lw_12",   1'b0, 32'h12, 32'h0, 3'b010, 2, 32'hDEAD55EF, 1'b0);
`endif
        issue("sw_1000", 1'b1, 32'h1000, 32'h1, 3'b010, 2, 32'h0, 1'b0);
        issue("lw_0",    1'b0, 32'h0, 32'h0, 3'b010, 2, 32'h00000001, 1'b0);
        issue("ld_f3_3", 1'b0, 32'h10, 32'h0, 3'b011, 2, 32'h0, 1'b1);
        issue("st_f3_7", 1'b1, 32'h10, 32'h12345678, 3'b111, 2, 32'h0, 1'b1);
        issue("lw_10c",  1'b0, 32'h10, 32'h0, 3'b010, 2, 32'hDEAD55EF, 1'b0);

        // A request held while busy must be ignored, not queued
        issue("lw_20",   1'b0, 32'h20, 32'h0, 3'b010, 1, 32'h0, 1'b0);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_addr   = 32'h30;
        bus.req_wdata  = 32'hBAD0BAD0;
        bus.req_funct3 = 3'b010;
        check_bit("busy_ready_0", bus.req_ready, 1'b0);
        @(negedge clk);
        check_bit("busy_ready_1", bus.req_ready, 1'b0);
        bus.req_valid = 1'b0;
        issue("lw_30",   1'b0, 32'h30, 32'h0, 3'b010, 1, 32'h0, 1'b0);

        // Reset mid-store: the store is dropped, storage is preserved
        issue("sw_20_rst", 1'b1, 32'h20, 32'h1234, 3'b010, 0, 32'h0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_bit("rst_mid_rsp_valid", bus.rsp_valid, 1'b0);
            check_bit("rst_mid_ready", bus.req_ready, 1'b0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_bit("rst_rel_ready", bus.req_ready, 1'b1);
        issue("lw_20_after", 1'b0, 32'h20, 32'h0, 3'b010, 1, 32'h0, 1'b0);

        // Randomized traffic against the reference model
        for (int k = 0; k < 400; k++) begin
            rw = 1'($urandom_range(0, 1));
            rf = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
            rd = $urandom;
            issue("rand", rw, ra, rd, rf, 1, 32'h0, 1'b0);
        end

        // Drain outstanding responses
        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding, required 0", sbq.size());
        end
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, giving storage depth in 32-bit words (power of two).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, giving added response latency in cycles (0..15).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  Rising-edge clock for all state.
REQ-005 rst  input  1  Asynchronous, active-high reset.
REQ-006 req_valid  input  1  Core presents a request.
REQ-007 req_ready  output  1  Responder can accept a request.
REQ-008 req_write  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  Byte address.
REQ-010 req_wdata  input  32  Store data, right-aligned.
REQ-011 req_funct3  input  3  Access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-012 rsp_valid  output  1  One-cycle response strobe.
REQ-013 rsp_rdata  output  32  Load data, extended per funct3.
REQ-014 rsp_error  output  1  Access faulted. Qualified by rsp_valid.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, RESPOND.
REQ-016 req_ready SHALL be 1 only when the FSM is in IDLE and rst is low.
REQ-017 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; all req_* fields are latched at that edge.
REQ-018 On accept, the FSM SHALL go to WAIT and load a wait counter with WAIT_CYCLES, or go directly to RESPOND if WAIT_CYCLES=0.
REQ-019 WAIT SHALL decrement the counter each cycle and go to RESPOND when the counter reaches 1.
REQ-020 rsp_valid SHALL be high for exactly one cycle, WAIT_CYCLES+1 cycles after the accepting edge; the FSM then returns to IDLE.
REQ-021 There SHALL be no response backpressure; back-to-back requests SHALL be spaced at least WAIT_CYCLES+2 cycles apart.
REQ-022 The word index SHALL be req_addr[log2(DEPTH_WORDS)+1:2]; addresses beyond the depth wrap modulo DEPTH_WORDS with no error.
REQ-023 Stores SHALL write only the addressed byte lanes: SB selects lane addr[1:0]; SH selects lanes per addr[1]; SW writes all four lanes.
REQ-024 Stores SHALL commit on the edge that enters RESPOND; for a store, rsp_rdata is 0.
REQ-025 Load data SHALL be shifted down by the byte offset: B/H sign-extend, BU/HU zero-extend, W passes the full word.
REQ-026 The loaded word SHALL reflect all stores committed before the request was accepted.
REQ-027 funct3 011, 110 and 111 SHALL produce rsp_error=1, rsp_rdata=0 and no write.
REQ-028 req_valid held high while req_ready=0 SHALL be ignored and does not queue a request.

Reset
REQ-029 While rst is high: FSM in IDLE, wait counter 0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0.
REQ-030 Reset asserted mid-transaction SHALL drop the pending request; a store not yet committed SHALL NOT write.
REQ-031 Reset SHALL NOT clear storage contents.

Configuration
REQ-032 The macro MEM_MISALIGN_TRAP_EN SHALL control misaligned-access handling.
REQ-033 With MEM_MISALIGN_TRAP_EN defined: a halfword with addr[0]=1, or a word with addr[1:0]≠0, SHALL produce rsp_error=1, rsp_rdata=0 and no write, at normal latency.
REQ-034 Without MEM_MISALIGN_TRAP_EN: the low address bits SHALL be forced aligned (H clears bit 0, W clears bits 1:0) and the access completes with rsp_error=0.

Structure
REQ-035 Package mem_pkg SHALL hold the FSM state enum (IDLE, WAIT, RESPOND) and the funct3 size-code localparams.
REQ-036 Sub-module mem_array SHALL be a single-port synchronous RAM with DEPTH_WORDS x 32 storage, 4 byte write enables and registered read data.
REQ-037 Lane selection and extension logic SHALL be in mem_responder; mem_array SHALL contain no protocol logic.

Verification
REQ-038 Reset, then SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_rdata=0xDEADBEEF, rsp_error=0, rsp_valid exactly 3 cycles after each accept (WAIT_CYCLES=2).
REQ-039 After REQ-038: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-040 SB 0x11 data 0x55 over 0xDEADBEEF, then LW 0x10 -> 0xDEAD55EF.
REQ-041 With DEPTH_WORDS=1024: SW 0x1000 data 0x1, then LW 0x0 -> 0x00000001 (wrap-around).
REQ-042 LW 0x12: with MEM_MISALIGN_TRAP_EN, rsp_error=1 and rsp_rdata=0; without it, result equals LW 0x10.
REQ-043 Assert rst one cycle after accepting SW 0x20 data 0x1234, release it, then LW 0x20 -> prior contents unchanged, rsp_valid low during reset, req_ready=1 the cycle after rst deasserts.
